// File: rtl/nw_pkg.sv
// rtl/nw_pkg.sv - shared types for the NW alignment column builder
package nw_pkg;

  // Default geometry; the top's parameters default to these values
  localparam int NW_LENGTH      = 10;
  localparam int NW_CWIDTH      = 2;
  localparam int NW_CORD_LENGTH = 8;

  // Traceback step between two consecutive coordinates
  typedef enum logic [1:0] {
    STEP_DIAG = 2'd0,
    STEP_UP   = 2'd1,
    STEP_LEFT = 2'd2,
    STEP_BAD  = 2'd3
  } step_t;

  // Builder FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Coordinate as carried on in_coord: x in the upper half, y in the lower half
  typedef struct packed {
    logic [NW_CORD_LENGTH-1:0] x;
    logic [NW_CORD_LENGTH-1:0] y;
  } coord_t;

  // One alignment column held in the output register
  typedef struct packed {
    logic [NW_CWIDTH-1:0] c1;
    logic                 gap1;
    logic [NW_CWIDTH-1:0] c2;
    logic                 gap2;
    logic                 last;
  } column_t;

endpackage

// File: rtl/nw_step_decode.sv
// rtl/nw_step_decode.sv - classifies the step from prev to cur coordinate
module nw_step_decode
  import nw_pkg::*;
#(
  parameter int LENGTH = NW_LENGTH
) (
  input  logic [2*NW_CORD_LENGTH-1:0] prev,
  input  logic [2*NW_CORD_LENGTH-1:0] cur,
  output logic [1:0]                  step
);

  localparam logic [NW_CORD_LENGTH:0] LIM = (NW_CORD_LENGTH+1)'(LENGTH);

  coord_t p;
  coord_t c;
  logic   x_dec;
  logic   y_dec;
  logic   x_same;
  logic   y_same;
  logic   in_range;
  step_t  step_v;

  assign p = coord_t'(prev);
  assign c = coord_t'(cur);

  // Compare one bit wider so that a wrapped cur (e.g. 0 -> all-ones) never looks like a decrement
  assign x_dec    = {1'b0, p.x} == ({1'b0, c.x} + 1'b1);
  assign y_dec    = {1'b0, p.y} == ({1'b0, c.y} + 1'b1);
  assign x_same   = p.x == c.x;
  assign y_same   = p.y == c.y;
  assign in_range = ({1'b0, c.x} < LIM) && ({1'b0, c.y} < LIM);

  // Only single-cell moves towards the origin inside the grid are legal
  always_comb begin
    step_v = STEP_BAD;
    if (in_range) begin
      if (x_dec && y_dec) begin
        step_v = STEP_DIAG;
      end else if (x_same && y_dec) begin
        step_v = STEP_UP;
      end else if (x_dec && y_same) begin
        step_v = STEP_LEFT;
      end
    end
  end

  assign step = step_v;

endmodule

// File: rtl/nw_align_builder.sv
// rtl/nw_align_builder.sv - turns a traceback coordinate stream into alignment columns
module nw_align_builder
  import nw_pkg::*;
#(
  parameter int LENGTH      = NW_LENGTH,
  parameter int CWIDTH      = NW_CWIDTH,
  parameter int CORD_LENGTH = NW_CORD_LENGTH,
  parameter int CNT_W       = $clog2(2*LENGTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*CORD_LENGTH-1:0] in_coord,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CWIDTH-1:0]        out_c1,
  output logic [CWIDTH-1:0]        out_c2,
  output logic                     out_gap1,
  output logic                     out_gap2,
  output logic                     out_last,
  output logic                     done,
  output logic                     error,
  output logic [CNT_W-1:0]         col_count,
  output logic [CNT_W-1:0]         match_count,
  output logic [CNT_W-1:0]         gap_count
);

  localparam logic [NW_CORD_LENGTH-1:0] CORNER = NW_CORD_LENGTH'(LENGTH-1);

  state_t                     state;
  state_t                     state_n;
  coord_t                     cur;
  coord_t                     prev_q;
  column_t                    col_q;
  column_t                    run_col;
  column_t                    last_col;
  logic                       out_valid_q;
  logic                       done_q;
  logic [1:0]                 step_raw;
  step_t                      step;
  logic                       in_hs;
  logic                       out_hs;
  logic                       first_ok;
  logic                       cur_origin;
  logic                       flush_load;
  logic [NW_CWIDTH-1:0]       c1_prev;
  logic [NW_CWIDTH-1:0]       c2_prev;
  logic [NW_CWIDTH-1:0]       c1_zero;
  logic [NW_CWIDTH-1:0]       c2_zero;

  function automatic logic [NW_CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] str,
                                                   input logic [NW_CORD_LENGTH-1:0] idx);
    logic [LENGTH*CWIDTH-1:0] sh;
    sh = str >> (idx * CWIDTH);
    return sh[NW_CWIDTH-1:0];
  endfunction

  nw_step_decode #(.LENGTH(LENGTH)) u_step_decode (
    .prev (prev_q),
    .cur  (cur),
    .step (step_raw)
  );

  assign step       = step_t'(step_raw);
  assign cur        = coord_t'(in_coord);
  assign first_ok   = (cur.x == CORNER) && (cur.y == CORNER);
  assign cur_origin = (cur.x == '0) && (cur.y == '0);
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;

  // The final (0,0) column is loaded only once, as soon as the slot frees up
  assign flush_load = (state == ST_FLUSH) && !(out_valid_q && col_q.last) &&
                      (!out_valid_q || out_ready);

  assign c1_prev = char_at(s1, prev_q.y);
  assign c2_prev = char_at(s2, prev_q.x);
  assign c1_zero = char_at(s1, '0);
  assign c2_zero = char_at(s2, '0);

  // Column describing prev for the step just taken; gap sides carry a zero character
  always_comb begin
    run_col = '0;
    case (step)
      STEP_DIAG: begin
        run_col.c1 = c1_prev;
        run_col.c2 = c2_prev;
      end
      STEP_UP: begin
        run_col.c1   = c1_prev;
        run_col.gap2 = 1'b1;
      end
      STEP_LEFT: begin
        run_col.gap1 = 1'b1;
        run_col.c2   = c2_prev;
      end
      default: run_col = '0;
    endcase
  end

  // Terminal diagonal column for the origin cell
  always_comb begin
    last_col      = '0;
    last_col.c1   = c1_zero;
    last_col.c2   = c2_zero;
    last_col.last = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (in_hs) begin
          state_n = first_ok ? ST_RUN : ST_ERR;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          if (step == STEP_BAD) begin
            state_n = ST_ERR;
          end else if (cur_origin) begin
            state_n = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (out_hs && col_q.last) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_ERR;
    endcase
  end

  // FSM outputs; everything is forced quiet during the reset cycle
  always_comb begin
    in_ready  = 1'b0;
    error     = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    if (!reset) begin
      out_valid = out_valid_q;
      done      = done_q;
      case (state)
        ST_IDLE:  in_ready = 1'b1;
        ST_RUN:   in_ready = !out_valid_q || out_ready;
        ST_ERR:   error    = 1'b1;
        default:  in_ready = 1'b0;
      endcase
    end
  end

  assign out_c1   = col_q.c1;
  assign out_c2   = col_q.c2;
  assign out_gap1 = col_q.gap1;
  assign out_gap2 = col_q.gap2;
  assign out_last = col_q.last;

  // Output register, previous coordinate and alignment statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      col_count   <= '0;
      match_count <= '0;
      gap_count   <= '0;
    end else begin
      done_q <= 1'b0;
      if (out_hs) begin
        col_count <= col_count + CNT_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (in_hs && first_ok) begin
            prev_q      <= cur;
            col_count   <= '0;
            match_count <= '0;
            gap_count   <= '0;
          end
        end
        ST_RUN: begin
          if (in_hs && (step != STEP_BAD)) begin
            col_q       <= run_col;
            out_valid_q <= 1'b1;
            prev_q      <= cur;
            if ((step == STEP_DIAG) && (c1_prev == c2_prev)) begin
              match_count <= match_count + CNT_W'(1);
            end
            if ((step == STEP_UP) || (step == STEP_LEFT)) begin
              gap_count <= gap_count + CNT_W'(1);
            end
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_load) begin
            col_q       <= last_col;
            out_valid_q <= 1'b1;
            if (c1_zero == c2_zero) begin
              match_count <= match_count + CNT_W'(1);
            end
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
            done_q      <= col_q.last;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
      // Entering ERR drops any pending column
      if (state_n == ST_ERR) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nw_align_builder.sv
// tb/tb_nw_align_builder.sv - randomized self-checking bench for nw_align_builder
module tb_nw_align_builder;

  localparam int L     = 4;
  localparam int CW    = 2;
  localparam int CL    = 8;
  localparam int CNT_W = $clog2(2*L);

  typedef logic [2*CL-1:0] crd_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [L*CW-1:0]   s1;
  logic [L*CW-1:0]   s2;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2*CL-1:0]   in_coord = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     out_c1;
  logic [CW-1:0]     out_c2;
  logic              out_gap1;
  logic              out_gap2;
  logic              out_last;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  col_count;
  logic [CNT_W-1:0]  match_count;
  logic [CNT_W-1:0]  gap_count;

  int n_checks = 0;
  int n_fail   = 0;

  crd_t       cq[$];
  crd_t       path[$];
  logic [6:0] eq[$];
  int         sq_m[$];
  int         sq_g[$];
  int         sq_c[$];
  int         done_iters[$];

  always #5 clk = ~clk;

  nw_align_builder #(
    .LENGTH      (L),
    .CWIDTH      (CW),
    .CORD_LENGTH (CL),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s1          (s1),
    .s2          (s2),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_coord    (in_coord),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_c1      (out_c1),
    .out_c2      (out_c2),
    .out_gap1    (out_gap1),
    .out_gap2    (out_gap2),
    .out_last    (out_last),
    .done        (done),
    .error       (error),
    .col_count   (col_count),
    .match_count (match_count),
    .gap_count   (gap_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ch(input logic [L*CW-1:0] s, input int k);
    logic [L*CW-1:0] sh;
    sh = s >> (k * CW);
    return int'(sh[CW-1:0]);
  endfunction

  function automatic crd_t mk(input int x, input int y);
    return {CL'(x), CL'(y)};
  endfunction

  // Reference: walk the coordinate list, one column per cell, origin column last
  task automatic add_path();
    int m = 0;
    int g = 0;
    for (int i = 0; i + 1 < path.size(); i++) begin
      int px = int'(path[i][2*CL-1:CL]);
      int py = int'(path[i][CL-1:0]);
      int cx = int'(path[i+1][2*CL-1:CL]);
      int cy = int'(path[i+1][CL-1:0]);
      int c1 = 0;
      int c2 = 0;
      int g1 = 0;
      int g2 = 0;
      if ((px - cx == 1) && (py - cy == 1)) begin
        c1 = ch(s1, py);
        c2 = ch(s2, px);
        if (c1 == c2) m++;
      end else if ((px == cx) && (py - cy == 1)) begin
        c1 = ch(s1, py);
        g2 = 1;
        g++;
      end else begin
        g1 = 1;
        c2 = ch(s2, px);
        g++;
      end
      eq.push_back({2'(c1), 1'(g1), 2'(c2), 1'(g2), 1'b0});
    end
    if (ch(s1, 0) == ch(s2, 0)) m++;
    eq.push_back({2'(ch(s1, 0)), 1'b0, 2'(ch(s2, 0)), 1'b0, 1'b1});
    sq_m.push_back(m);
    sq_g.push_back(g);
    sq_c.push_back(path.size());
    foreach (path[i]) cq.push_back(path[i]);
  endtask

  task automatic gen_diag();
    path.delete();
    for (int k = L - 1; k >= 0; k--) path.push_back(mk(k, k));
  endtask

  task automatic gen_random();
    int x = L - 1;
    int y = L - 1;
    int r;
    path.delete();
    path.push_back(mk(x, y));
    while (x > 0 || y > 0) begin
      r = $urandom_range(0, 2);
      if (r == 0 && x > 0 && y > 0) begin
        x--;
        y--;
      end else if (r == 1 && y > 0) begin
        y--;
      end else if (x > 0) begin
        x--;
      end else begin
        y--;
      end
      path.push_back(mk(x, y));
    end
  endtask

  task automatic clear_model();
    cq.delete();
    eq.delete();
    sq_m.delete();
    sq_g.delete();
    sq_c.delete();
    done_iters.delete();
  endtask

  // Feeds queued coordinates and scores every column, stall and done pulse
  task automatic drive(input int vp, input int rp, input int budget, input int stop_cols);
    int         it = 0;
    int         cols = 0;
    bit         lat = 1'b0;
    bit         hold = 1'b0;
    bit         ihs;
    bit         ohs;
    logic [6:0] held = '0;
    logic [6:0] oc;
    while ((cq.size() > 0 || eq.size() > 0 || sq_m.size() > 0) && it < budget) begin
      @(negedge clk);
      in_valid  = (cq.size() > 0) && ($urandom_range(0, 99) < vp);
      in_coord  = (cq.size() > 0) ? cq[0] : '0;
      out_ready = ($urandom_range(0, 99) < rp);
      #1;
      oc  = {out_c1, out_gap1, out_c2, out_gap2, out_last};
      ihs = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (lat) check("latency", out_valid, 1);
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_fields", oc, held);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (ohs) begin
        if (eq.size() == 0) check("extra_col", 1, 0);
        else check("column", oc, eq.pop_front());
        cols++;
      end
      if (done) begin
        done_iters.push_back(it);
        if (sq_m.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          check("match_count", match_count, sq_m.pop_front());
          check("gap_count", gap_count, sq_g.pop_front());
          check("col_count", col_count, sq_c.pop_front());
        end
        if (in_valid) check("accept_after_done", in_ready, 1);
      end
      lat  = ihs && (in_coord != mk(L - 1, L - 1));
      hold = out_valid && !out_ready;
      held = oc;
      if (ihs) void'(cq.pop_front());
      it++;
      if (stop_cols > 0 && cols >= stop_cols) break;
    end
    if (it >= budget) check("timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_state", {out_valid, error, done, in_ready}, 4'b0001);
    check("post_reset_counts", {col_count, match_count, gap_count}, '0);
  endtask

  task automatic feed(input crd_t c);
    @(negedge clk);
    in_valid  = 1'b1;
    in_coord  = c;
    out_ready = 1'b1;
    #1;
    check("feed_ready", in_ready, 1);
  endtask

  task automatic expect_err(input string tag);
    check(tag, {error, in_ready, out_valid}, 3'b100);
  endtask

  initial begin
    s1 = {2'd3, 2'd2, 2'd1, 2'd0};
    s2 = {2'd3, 2'd2, 2'd1, 2'd0};
    clear_model();
    do_reset();

    // Pure diagonal with a free-running sink
    gen_diag();
    add_path();
    drive(100, 100, 200, 0);

    // Mixed steps: UP, DIAG, DIAG, LEFT, DIAG
    path.delete();
    path.push_back(mk(3, 3));
    path.push_back(mk(3, 2));
    path.push_back(mk(2, 1));
    path.push_back(mk(1, 0));
    path.push_back(mk(0, 0));
    add_path();
    check("mixed_ref_gaps", sq_g[0], 2);
    check("mixed_ref_matches", sq_m[0], 1);
    drive(100, 100, 200, 0);

    // Diagonal with a stalling sink
    gen_diag();
    add_path();
    drive(100, 35, 400, 0);

    // Back-to-back alignments at full throughput
    clear_model();
    gen_diag();
    add_path();
    gen_diag();
    add_path();
    drive(100, 100, 200, 0);
    check("b2b_done_count", done_iters.size(), 2);
    if (done_iters.size() == 2) begin
      check("b2b_first_done_cycle", done_iters[0], 6);
      check("b2b_second_done_cycle", done_iters[1], 12);
    end

    // Random strings, random paths, random handshake pressure
    for (int n = 0; n < 10; n++) begin
      clear_model();
      s1 = L*CW'($urandom());
      s2 = L*CW'($urandom());
      gen_random();
      add_path();
      drive(70, 60, 600, 0);
    end

    // Reset in the middle of an alignment, then a clean replay
    s1 = {2'd3, 2'd2, 2'd1, 2'd0};
    s2 = {2'd3, 2'd2, 2'd1, 2'd0};
    clear_model();
    gen_diag();
    add_path();
    drive(100, 100, 50, 2);
    clear_model();
    do_reset();
    gen_diag();
    add_path();
    drive(100, 100, 200, 0);

    // Wrong first coordinate
    do_reset();
    feed(mk(2, 3));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    expect_err("err_first_coord");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_coord = mk(3, 3);
      #1;
      expect_err("err_sticky");
    end

    // Illegal jump
    do_reset();
    feed(mk(3, 3));
    feed(mk(1, 2));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    expect_err("err_bad_step");

    // x wraps below zero: looks like a decrement modulo 2^CL but is out of range
    do_reset();
    feed(mk(3, 3));
    feed(mk(2, 3));
    feed(mk(1, 3));
    feed(mk(0, 3));
    feed(mk(255, 2));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    expect_err("err_out_of_range");

    // Recovery after error
    do_reset();
    clear_model();
    gen_diag();
    add_path();
    drive(100, 100, 200, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
